// File: rtl/psm_pkg.sv
// Shared types and default timing for the pulse-skip rail arbiter.
package psm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        DEAD    = 2'd3
    } psm_state_t;

    // Bit positions of each rail in the eligibility/emergency vectors.
    localparam int RAIL_A = 0;
    localparam int RAIL_B = 1;

    localparam int DEF_PULSE_CYCLES = 8;
    localparam int DEF_DEAD_CYCLES  = 2;
    localparam int DEF_MAX_CONSEC   = 3;
    localparam int DEF_SHARE_COUNT  = 4;

endpackage

// File: rtl/psm_share_detect.sv
// Detects sustained demand from both rails, counted on ADC sample strobes.
module psm_share_detect
    import psm_pkg::*;
#(
    parameter int SHARE_COUNT = DEF_SHARE_COUNT
) (
    input  logic clk,
    input  logic reset_in,
    input  logic drdy_in,
    input  logic req_a,
    input  logic req_b,
    output logic load_sharing_active
);

    localparam int SW = $clog2(SHARE_COUNT + 1);
    localparam logic [SW-1:0] SHARE_MAX  = SW'(SHARE_COUNT);
    localparam logic [SW-1:0] SHARE_LAST = SW'(SHARE_COUNT - 1);

    logic [SW-1:0] share_cnt;

    // Saturating run-length of qualifying samples; any broken sample restarts the run.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            share_cnt           <= '0;
            load_sharing_active <= 1'b0;
        end else if (drdy_in) begin
            if (req_a & req_b) begin
                if (share_cnt != SHARE_MAX) begin
                    share_cnt <= share_cnt + 1'b1;
                end
                if (share_cnt >= SHARE_LAST) begin
                    load_sharing_active <= 1'b1;
                end
            end else begin
                share_cnt           <= '0;
                load_sharing_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/psm_rail_arbiter.sv
// Arbitrates one power stage between rail A and rail B with fixed-width
// pulses, dead time, A-priority and starvation protection for B.
module psm_rail_arbiter
    import psm_pkg::*;
#(
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
    parameter int MAX_CONSEC   = DEF_MAX_CONSEC,
    parameter int SHARE_COUNT  = DEF_SHARE_COUNT
) (
    input  logic clk,
    input  logic reset_in,
    input  logic drdy_in,
    input  logic req_a,
    input  logic req_b,
    input  logic emerg_a,
    input  logic emerg_b,
    input  logic abort_a,
    input  logic abort_b,
    output logic grant_a,
    output logic grant_b,
    output logic load_sharing_active,
    output logic busy
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int CW = $clog2(MAX_CONSEC + 1);

    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);
    localparam logic [DW-1:0] DEAD_LOAD  = (DEAD_CYCLES > 0) ? DW'(DEAD_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);

    psm_state_t    state_q, state_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [CW-1:0] consec_a_q, consec_a_d;
    logic [1:0]    eff;
    logic [1:0]    emerg;
    logic          pick_a, pick_b;
    logic          abort_cur;

    assign eff[RAIL_A]   = (req_a | emerg_a) & ~abort_a;
    assign eff[RAIL_B]   = (req_b | emerg_b) & ~abort_b;
    assign emerg[RAIL_A] = emerg_a;
    assign emerg[RAIL_B] = emerg_b;

    // Next-state: arbitration in IDLE, pulse timing in GRANT_x, dead-time countdown in DEAD.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        consec_a_d  = consec_a_q;
        pick_a      = 1'b0;
        pick_b      = 1'b0;
        abort_cur   = (state_q == GRANT_A) ? abort_a : abort_b;

        case (state_q)
            IDLE: begin
                if (eff[RAIL_A] && eff[RAIL_B]) begin
                    // Emergency outranks normal; on a tie A wins unless B is being starved.
                    if (emerg[RAIL_A] != emerg[RAIL_B]) begin
                        pick_a = emerg[RAIL_A];
                    end else begin
                        pick_a = (consec_a_q != CONSEC_MAX);
                    end
                    pick_b = ~pick_a;
                end else begin
                    pick_a = eff[RAIL_A];
                    pick_b = eff[RAIL_B];
                end

                if (pick_a) begin
                    state_d     = GRANT_A;
                    pulse_cnt_d = PULSE_LOAD;
                    if (!eff[RAIL_B]) begin
                        consec_a_d = '0;
                    end else if (consec_a_q != CONSEC_MAX) begin
                        consec_a_d = consec_a_q + 1'b1;
                    end
                end else if (pick_b) begin
                    state_d     = GRANT_B;
                    pulse_cnt_d = PULSE_LOAD;
                    consec_a_d  = '0;
                end
            end

            GRANT_A, GRANT_B: begin
                if (abort_cur || (pulse_cnt_q == '0)) begin
                    if (DEAD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DEAD;
                        dead_cnt_d = DEAD_LOAD;
                    end
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 1'b1;
                end
            end

            DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state so they align with it.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            dead_cnt_q  <= '0;
            consec_a_q  <= '0;
            grant_a     <= 1'b0;
            grant_b     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            consec_a_q  <= consec_a_d;
            grant_a     <= (state_d == GRANT_A);
            grant_b     <= (state_d == GRANT_B);
            busy        <= (state_d != IDLE);
        end
    end

    psm_share_detect #(
        .SHARE_COUNT(SHARE_COUNT)
    ) u_share_detect (
        .clk                (clk),
        .reset_in           (reset_in),
        .drdy_in            (drdy_in),
        .req_a              (req_a),
        .req_b              (req_b),
        .load_sharing_active(load_sharing_active)
    );

endmodule

// File: tb/tb_psm_rail_arbiter.sv
// Bench for psm_rail_arbiter: directed scenarios then random traffic, all
// checked against a pulse-schedule model kept in terms of clock-edge indices.
module tb_psm_rail_arbiter;

    localparam int P = 8;
    localparam int D = 2;
    localparam int M = 3;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset_in, drdy_in, req_a, req_b, emerg_a, emerg_b, abort_a, abort_b;
    logic grant_a, grant_b, load_sharing_active, busy;

    always #5 clk = ~clk;

    psm_rail_arbiter #(
        .PULSE_CYCLES(P), .DEAD_CYCLES(D), .MAX_CONSEC(M), .SHARE_COUNT(S)
    ) dut (
        .clk                (clk),
        .reset_in           (reset_in),
        .drdy_in            (drdy_in),
        .req_a              (req_a),
        .req_b              (req_b),
        .emerg_a            (emerg_a),
        .emerg_b            (emerg_b),
        .abort_a            (abort_a),
        .abort_b            (abort_b),
        .grant_a            (grant_a),
        .grant_b            (grant_b),
        .load_sharing_active(load_sharing_active),
        .busy               (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edge counter plus the edge window of the current pulse.
    int e         = 0;
    int m_rail    = 0;   // 0 none, 1 rail A, 2 rail B
    int g_first   = -10;
    int g_last    = -10;
    int idle_edge = 0;   // state is IDLE after this edge and later
    int m_consec  = 0;
    int m_share   = 0;
    bit m_lsa     = 1'b0;

    int exp_seq[8] = '{1, 1, 1, 2, 1, 1, 1, 2};

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, e, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rail    = 0;
        g_first   = -10;
        g_last    = -10;
        idle_edge = e;
        m_consec  = 0;
        m_share   = 0;
        m_lsa     = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs just sampled.
    task automatic model_edge();
        int cur, sa, sb, win;
        bit ea, eb;
        e++;
        cur = e - 1;
        ea  = (req_a | emerg_a) & ~abort_a;
        eb  = (req_b | emerg_b) & ~abort_b;
        if (cur >= idle_edge) begin
            sa  = ea ? (emerg_a ? 2 : 1) : 0;
            sb  = eb ? (emerg_b ? 2 : 1) : 0;
            win = 0;
            if (sa > sb)      win = 1;
            else if (sb > sa) win = 2;
            else if (sa > 0)  win = (m_consec == M) ? 2 : 1;
            if (win == 1)      m_consec = eb ? ((m_consec < M) ? m_consec + 1 : M) : 0;
            else if (win == 2) m_consec = 0;
            if (win != 0) begin
                m_rail    = win;
                g_first   = e;
                g_last    = e + P - 1;
                idle_edge = g_last + D + 1;
            end
        end else if (cur >= g_first && cur <= g_last) begin
            if ((m_rail == 1 && abort_a) || (m_rail == 2 && abort_b)) begin
                g_last    = cur;
                idle_edge = g_last + D + 1;
            end
        end
        if (drdy_in) begin
            if (req_a & req_b) begin
                m_share = (m_share < S) ? m_share + 1 : S;
                if (m_share == S) m_lsa = 1'b1;
            end else begin
                m_share = 0;
                m_lsa   = 1'b0;
            end
        end
    endtask

    task automatic step(input logic a, input logic b, input logic ea, input logic eb,
                        input logic aa, input logic ab, input logic dr);
        bit in_pulse;
        req_a = a; req_b = b; emerg_a = ea; emerg_b = eb;
        abort_a = aa; abort_b = ab; drdy_in = dr;
        @(posedge clk);
        model_edge();
        #1;
        in_pulse = (e >= g_first) && (e <= g_last);
        check("grant_a", grant_a, in_pulse && m_rail == 1);
        check("grant_b", grant_b, in_pulse && m_rail == 2);
        check("busy", busy, e < idle_edge);
        check("load_sharing_active", load_sharing_active, m_lsa);
        check("mutex", grant_a & grant_b, 1'b0);
    endtask

    // Reset asserted between edges: outputs must drop without waiting for a clock.
    task automatic reset_mid();
        reset_in = 1'b1;
        #1;
        check("rst_async_grant_a", grant_a, 1'b0);
        check("rst_async_grant_b", grant_b, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_lsa", load_sharing_active, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic share_sample(input logic a, input logic b);
        step(a, b, 0, 0, 1, 1, 1);
        step(a, b, 0, 0, 1, 1, 0);
        step(a, b, 0, 0, 1, 1, 0);
    endtask

    initial begin
        logic [11:0] gvec;
        logic [3:0]  bvec;
        logic        gb_seen;
        int          starts[$];
        int          low_run, min_gap, obs;
        bit          prev_a, prev_b, seen_pulse;

        reset_in = 1'b1;
        req_a = 0; req_b = 0; emerg_a = 0; emerg_b = 0;
        abort_a = 0; abort_b = 0; drdy_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant_a", grant_a, 1'b0);
        check("reset_grant_b", grant_b, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_lsa", load_sharing_active, 1'b0);
        reset_in = 1'b0;
        model_reset();

        // 1: reset three cycles into an A pulse
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t1_in_pulse", grant_a, 1'b1);
        reset_mid();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        check("t1_idle_after_reset", busy, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t1_new_request", grant_a, 1'b1);

        // 2: single held request
        drain();
        gb_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            gvec[i] = grant_a;
            gb_seen = gb_seen | grant_b;
        end
        checkv("t2_grant_pattern", int'(gvec), int'(12'b1000_1111_1111));
        check("t2_no_grant_b", gb_seen, 1'b0);

        // 3: both rails held, B forced after three A pulses
        drain();
        prev_a = 0; prev_b = 0; low_run = 0; min_gap = 1000; seen_pulse = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 0, 0, 0, 0, 0);
            if ((grant_a && !prev_a) || (grant_b && !prev_b)) begin
                starts.push_back(grant_a ? 1 : 2);
                if (seen_pulse && low_run < min_gap) min_gap = low_run;
                seen_pulse = 1;
            end
            low_run = (grant_a || grant_b) ? 0 : low_run + 1;
            prev_a = grant_a; prev_b = grant_b;
        end
        for (int i = 0; i < 8; i++) begin
            obs = (i < starts.size()) ? starts[i] : 0;
            checkv("t3_starvation_seq", obs, exp_seq[i]);
        end
        check("t3_dead_gap", min_gap >= D, 1'b1);

        // 4: emergency priority
        drain();
        step(1, 0, 0, 1, 0, 0, 0);
        check("t4_emerg_b_wins", grant_b, 1'b1);
        drain();
        step(0, 0, 1, 1, 0, 0, 0);
        check("t4_both_emerg_a_wins", grant_a, 1'b1);

        // 5: abort on the fourth cycle of an A pulse
        drain();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("t5_pulse_cycle4", grant_a, 1'b1);
        step(1, 0, 0, 0, 1, 0, 0);
        check("t5_abort_drops", grant_a, 1'b0);
        bvec[0] = busy;
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 0, 0, 1, 0, 0);
            bvec[i] = busy;
        end
        checkv("t5_dead_then_idle", int'(bvec), int'(4'b0011));
        check("t5_a_ineligible", grant_a, 1'b0);

        // 6: load sharing detection (aborts keep the stage idle)
        drain();
        for (int i = 0; i < 3; i++) begin
            share_sample(1, 1);
            check("t6_not_yet", load_sharing_active, 1'b0);
        end
        step(1, 1, 0, 0, 1, 1, 1);
        check("t6_rises_on_4th", load_sharing_active, 1'b1);
        share_sample(1, 0);
        check("t6_clears", load_sharing_active, 1'b0);
        for (int i = 0; i < 3; i++) begin
            share_sample(1, 1);
            check("t6_run1_low", load_sharing_active, 1'b0);
        end
        share_sample(0, 1);
        for (int i = 0; i < 3; i++) begin
            share_sample(1, 1);
            check("t6_run2_low", load_sharing_active, 1'b0);
        end

        // Random traffic with occasional mid-cycle reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) reset_mid();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
